ahb_mtx_arb_out: RTL

//  Parametrised output-stage arbiter for the AHB bus matrix: picks which input port drives a shared slave port.

---
 rtl/ahb_mtx_arb_out_if.sv | 26 ++
 rtl/ahb_mtx_arb_out.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_arb_out_if.sv
// Bus-matrix output-stage arbitration bundle: per-port requests and current transfer
// attributes in, registered grant out.
interface ahb_mtx_arb_out_if #(
  parameter int unsigned NUM_PORTS = 6,
  parameter int unsigned PORT_W    = 3
);
  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic                 arb_hold;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, arb_hold
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, arb_hold
  );
endinterface

// File: rtl/ahb_mtx_arb_out.sv
// Output-stage arbiter for one AHB matrix slave port: fixed-priority or round-robin
// grant, held across locked transfers and bursts so a burst is never split.
module ahb_mtx_arb_out #(
  parameter int unsigned          NUM_PORTS = 6,
  parameter int unsigned          PORT_W    = 3,
  parameter logic [NUM_PORTS-1:0] PORT_MASK = 6'b101100,
  parameter int unsigned          ARB_MODE  = 0,
  parameter int unsigned          INCR_MAX  = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_mtx_arb_out_if.slave    bus
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  localparam logic [3:0]        INCR_LEN_M1 = 4'(INCR_MAX - 1);
  localparam logic [PORT_W-1:0] RR_RESET    = PORT_W'(NUM_PORTS - 1);

  logic [PORT_W-1:0]    r_addr;
  logic                 r_no_port;
  logic [3:0]           r_rem;
  logic [PORT_W-1:0]    r_rr_last;

  htrans_e              w_trans;
  hburst_e              w_burst;
  logic [3:0]           w_len_m1;
  logic                 w_active;
  logic                 w_hold;
  logic [NUM_PORTS-1:0] w_eff;
  logic                 w_lo_found;
  logic [PORT_W-1:0]    w_lo;
  logic                 w_lo_req;
  logic                 w_hi_found;
  logic [PORT_W-1:0]    w_hi;
  logic                 w_hi_req;
  logic [PORT_W-1:0]    w_win;
  logic                 w_win_req;
  logic [PORT_W-1:0]    w_addr_nxt;
  logic                 w_np_nxt;
  logic [3:0]           w_rem_nxt;
  logic [PORT_W-1:0]    w_rr_nxt;

  assign w_trans  = htrans_e'(bus.HTRANSM);
  assign w_burst  = hburst_e'(bus.HBURSTM);
  assign w_active = ~r_no_port & bus.HSELM;

  // Burst length minus one, i.e. beats still owed once the NONSEQ beat is accepted
  always_comb begin
    w_len_m1 = '0;
    unique case (w_burst)
      BU_SINGLE:           w_len_m1 = 4'd0;
      BU_INCR:             w_len_m1 = INCR_LEN_M1;
      BU_WRAP4,  BU_INCR4:  w_len_m1 = 4'd3;
      BU_WRAP8,  BU_INCR8:  w_len_m1 = 4'd7;
      BU_WRAP16, BU_INCR16: w_len_m1 = 4'd15;
      default:             w_len_m1 = 4'd0;
    endcase
  end

  assign w_hold = bus.HMASTLOCKM |
                  (w_active & (((w_trans == TR_NONSEQ) && (w_len_m1 != 4'd0)) ||
                               ((w_trans == TR_SEQ)    && (r_rem > 4'd1))     ||
                               ((w_trans == TR_BUSY)   && (r_rem != 4'd0))));

  // The currently granted port keeps competing while it still drives a live transfer
  always_comb begin
    w_eff = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_eff[i] = PORT_MASK[i] &
                 (bus.req_port[i] |
                  (w_active & (w_trans != TR_IDLE) & (r_addr == PORT_W'(i))));
    end
  end

  // Round-robin: first eligible index above the last winner, else wrap to the lowest
  always_comb begin
    w_lo_found = 1'b0;
    w_lo       = '0;
    w_lo_req   = 1'b0;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_hi_req   = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_eff[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo       = PORT_W'(i);
        w_lo_req   = bus.req_port[i];
      end
      if (w_eff[i] && !w_hi_found && (i > 32'(r_rr_last))) begin
        w_hi_found = 1'b1;
        w_hi       = PORT_W'(i);
        w_hi_req   = bus.req_port[i];
      end
    end
    if ((ARB_MODE == 1) && w_hi_found) begin
      w_win     = w_hi;
      w_win_req = w_hi_req;
    end else begin
      w_win     = w_lo;
      w_win_req = w_lo_req;
    end
  end

  always_comb begin
    w_addr_nxt = r_addr;
    w_np_nxt   = r_no_port;
    w_rr_nxt   = r_rr_last;
    w_rem_nxt  = r_rem;

    if (!w_hold) begin
      if (|w_eff) begin
        w_addr_nxt = w_win;
        w_np_nxt   = 1'b0;
        if (w_win_req) begin
          w_rr_nxt = w_win;
        end
      end else if (!bus.HSELM) begin
        w_np_nxt = 1'b1;
      end
    end

    if (w_active) begin
      unique case (w_trans)
        TR_NONSEQ: w_rem_nxt = w_len_m1;
        TR_SEQ:    w_rem_nxt = (r_rem == 4'd0) ? 4'd0 : r_rem - 4'd1;
        TR_BUSY:   w_rem_nxt = r_rem;
        TR_IDLE:   w_rem_nxt = 4'd0;
        default:   w_rem_nxt = r_rem;
      endcase
    end

    if (w_np_nxt) begin
      w_rem_nxt = 4'd0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_addr    <= '0;
      r_no_port <= 1'b1;
      r_rem     <= '0;
      r_rr_last <= RR_RESET;
    end else if (bus.HREADYM) begin
      r_addr    <= w_addr_nxt;
      r_no_port <= w_np_nxt;
      r_rem     <= w_rem_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  assign bus.addr_in_port = r_addr;
  assign bus.no_port      = r_no_port;
  assign bus.arb_hold     = w_hold;

endmodule
